// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scan controller.
// Row/column index 0 maps to bit 3 of the rows/cols buses.
package keypad_pkg;

   typedef logic [3:0] key_code_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_EVAL
   } scan_state_t;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_KEY,
      RES_MULTI
   } scan_res_t;

   localparam int unsigned FIFO_DEPTH = 4;

   // Codes count down from the top-left key so that row 0 / column 0 is 4'b1111.
   function automatic key_code_t make_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
      return {2'd3 - row_idx, 2'd3 - col_idx};
   endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Four-entry first-word-fall-through queue of key codes.
// A pop frees a slot in the same cycle, so push+pop on a full queue is accepted.
module keypad_fifo
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [3:0] push_code,
   input  logic       pop,
   output logic [3:0] head,
   output logic       full,
   output logic       empty
);

   logic [3:0] mem [FIFO_DEPTH];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       do_push;
   logic       do_pop;

   assign full    = (count == 3'(FIFO_DEPTH));
   assign empty   = (count == 3'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head reads as zero while empty so the output has a defined reset value.
   assign head    = empty ? 4'b0000 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_code;
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobing, row sampling, debounce with ghost
// rejection, and a small key-code queue drained by the MCU.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ack,
   output logic       key_down,
   output logic       overflow,
   input  logic       clear_ovf
);

   localparam int unsigned    T_W    = $clog2(SETTLE_CYCLES);
   localparam logic [T_W-1:0] T_LAST = T_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]     DB_MAX = 4'(DEBOUNCE_SCANS);

   logic [3:0]     rows_p0;
   logic [3:0]     rows_p1;
   scan_state_t    state;
   scan_state_t    state_nx;
   logic [1:0]     col;
   logic [1:0]     col_nx;
   logic [T_W-1:0] tcnt;
   logic [T_W-1:0] tcnt_nx;
   logic           sample;
   logic [3:0]     snap [4];

   logic [4:0]     nzero;
   key_code_t      hit_code;
   scan_res_t      res;

   scan_res_t      cand_res;
   key_code_t      cand_code;
   logic [3:0]     stable_cnt;
   logic           rep_key;
   key_code_t      rep_code;
   logic           same;
   logic [3:0]     cnt_nx;
   logic           settled;
   logic           push;
   logic           fifo_full;
   logic           fifo_empty;
   logic           drop;

   // Stage p0/p1: two-flop synchronizer for the asynchronous rows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows_p0 <= 4'b1111;
         rows_p1 <= 4'b1111;
      end else begin
         rows_p0 <= rows;
         rows_p1 <= rows_p0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         col   <= '0;
         tcnt  <= '0;
      end else begin
         state <= state_nx;
         col   <= col_nx;
         tcnt  <= tcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      col_nx   = col;
      tcnt_nx  = tcnt;
      sample   = 1'b0;
      if (!enable) begin
         state_nx = ST_IDLE;
         col_nx   = '0;
         tcnt_nx  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nx = ST_SCAN;
               col_nx   = '0;
               tcnt_nx  = '0;
            end
            ST_SCAN: begin
               if (tcnt == T_LAST) begin
                  sample  = 1'b1;
                  tcnt_nx = '0;
                  if (col == 2'd3) begin
                     state_nx = ST_EVAL;
                     col_nx   = '0;
                  end else begin
                     col_nx = col + 2'd1;
                  end
               end else begin
                  tcnt_nx = tcnt + T_W'(1);
               end
            end
            ST_EVAL: begin
               state_nx = ST_SCAN;
               col_nx   = '0;
               tcnt_nx  = '0;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // Strobes decode from registered state only, so they never glitch on input changes.
   assign cols = (state == ST_SCAN) ? ~(4'b1000 >> col) : 4'b1111;

   always_ff @(posedge clk) begin
      if (sample) snap[col] <= rows_p1;
   end

   always_comb begin
      nzero    = '0;
      hit_code = '0;
      for (int c = 0; c < 4; c++) begin
         for (int b = 0; b < 4; b++) begin
            if (!snap[c][b]) begin
               nzero    = nzero + 5'd1;
               hit_code = make_code(2'(3 - b), 2'(c));
            end
         end
      end
      if (nzero == 5'd0)      res = RES_NONE;
      else if (nzero == 5'd1) res = RES_KEY;
      else                    res = RES_MULTI;
   end

   always_comb begin
      same    = (res == cand_res) && ((res != RES_KEY) || (hit_code == cand_code));
      cnt_nx  = 4'd1;
      if (same) cnt_nx = (stable_cnt == DB_MAX) ? DB_MAX : stable_cnt + 4'd1;
      settled = (cnt_nx == DB_MAX);
      push    = (state == ST_EVAL) && enable && settled && (res == RES_KEY) &&
                (!rep_key || (rep_code != hit_code));
   end

   // Debounce state lives only while scanning; disabling forgets any held key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_res   <= RES_NONE;
         cand_code  <= '0;
         stable_cnt <= '0;
         rep_key    <= 1'b0;
         rep_code   <= '0;
         key_down   <= 1'b0;
      end else if (!enable) begin
         cand_res   <= RES_NONE;
         cand_code  <= '0;
         stable_cnt <= '0;
         rep_key    <= 1'b0;
         rep_code   <= '0;
         key_down   <= 1'b0;
      end else if (state == ST_EVAL) begin
         cand_res   <= res;
         cand_code  <= hit_code;
         stable_cnt <= cnt_nx;
         if (settled && (res == RES_KEY)) begin
            rep_key  <= 1'b1;
            rep_code <= hit_code;
            key_down <= 1'b1;
         end else if (settled && (res == RES_NONE)) begin
            rep_key  <= 1'b0;
            key_down <= 1'b0;
         end
      end
   end

   keypad_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_code (hit_code),
      .pop       (key_ack),
      .head      (key_code),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign key_valid = !fifo_empty;
   assign drop      = push && fifo_full && !(key_ack && key_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         overflow <= 1'b0;
      else if (drop)      overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model drives rows from cols, and a
// scoreboard queue holds the codes the controller is expected to deliver.
module tb_keypad_scan_ctrl;

   localparam int S = 8;
   localparam int D = 4;
   localparam int P = 4 * S + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       enable = 1'b0;
   logic       key_ack = 1'b0;
   logic       clear_ovf = 1'b0;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       overflow;

   logic [3:0] pr [4];
   logic [3:0] sb [$];
   logic       exp_ovf;
   int         n_vec = 0;
   int         n_err = 0;

   keypad_scan_ctrl #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .rows      (rows),
      .cols      (cols),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ack   (key_ack),
      .key_down  (key_down),
      .overflow  (overflow),
      .clear_ovf (clear_ovf)
   );

   always #5 clk = ~clk;

   // pr[r] bit (3-c) set means key at row r, column c is held down.
   always_comb begin
      rows = 4'b1111;
      for (int r = 0; r < 4; r++) rows[3 - r] = ~|(pr[r] & ~cols);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_push(input logic [3:0] code);
      if (sb.size() < 4) sb.push_back(code);
      else exp_ovf = 1'b1;
   endtask

   task automatic wait_cols(input logic [3:0] v, input string tag);
      int n = 0;
      while (cols !== v && n < 2 * P) begin
         @(negedge clk);
         n++;
      end
      if (cols !== v) check_eq(tag, 32'(cols), 32'(v));
   endtask

   task automatic sync_eval();
      wait_cols(4'b1111, "sync_eval_timeout");
   endtask

   task automatic hold_scans(input int n);
      repeat (n * P) @(negedge clk);
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++) pr[r] = 4'b0000;
   endtask

   task automatic press(input int r, input int c, input logic [3:0] code);
      sync_eval();
      pr[r][3 - c] = 1'b1;
      model_push(code);
   endtask

   task automatic do_ack(input string tag);
      logic [3:0] e;
      check_eq({tag, "_vld"}, 32'(key_valid), 32'd1);
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check_eq({tag, "_code"}, 32'(key_code), 32'(e));
         key_ack = 1'b1;
         @(negedge clk);
         key_ack = 1'b0;
         check_eq({tag, "_after"}, 32'(key_valid), 32'(sb.size() != 0));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      release_all();
      exp_ovf = 1'b0;

      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_cols", 32'(cols), 32'hF);
      check_eq("rst_vld", 32'(key_valid), 32'd0);
      check_eq("rst_code", 32'(key_code), 32'd0);
      check_eq("rst_down", 32'(key_down), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("scan_col0", 32'(cols), 32'h7);

      // Row 1 / column 2 held for D+3 scans
      press(1, 2, 4'b1001);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!key_valid && n < 10 * P);
      check_eq("press_latency", 32'(n), 32'(D * P + 1));
      check_eq("t1_code", 32'(key_code), 32'(sb[0]));
      repeat (3 * P - 1) @(negedge clk);
      check_eq("t1_down", 32'(key_down), 32'd1);
      do_ack("t1_ack");
      sync_eval();
      release_all();
      repeat (D * P) @(negedge clk);
      check_eq("t1_still_down", 32'(key_down), 32'd1);
      @(negedge clk);
      check_eq("t1_up", 32'(key_down), 32'd0);
      check_eq("t1_no_repush", 32'(key_valid), 32'd0);

      // Press too short to debounce
      sync_eval();
      pr[2][0] = 1'b1;
      hold_scans(D - 1);
      release_all();
      hold_scans(D + 1);
      check_eq("short_vld", 32'(key_valid), 32'd0);
      check_eq("short_down", 32'(key_down), 32'd0);

      // Ghost pattern on column 0 while a key is held
      press(0, 0, 4'b1111);
      hold_scans(D + 1);
      check_eq("pre_multi_down", 32'(key_down), 32'd1);
      pr[2][3] = 1'b1;
      hold_scans(D + 2);
      check_eq("multi_down", 32'(key_down), 32'd1);
      do_ack("multi_ack");
      sync_eval();
      release_all();
      hold_scans(D + 1);
      check_eq("multi_up", 32'(key_down), 32'd0);

      // Five presses without ack: fifth overflows
      press(0, 1, 4'b1110); hold_scans(D + 1); sync_eval(); release_all(); hold_scans(D + 1);
      press(1, 0, 4'b1011); hold_scans(D + 1); sync_eval(); release_all(); hold_scans(D + 1);
      press(2, 1, 4'b0110); hold_scans(D + 1); sync_eval(); release_all(); hold_scans(D + 1);
      press(3, 2, 4'b0001); hold_scans(D + 1); sync_eval(); release_all(); hold_scans(D + 1);
      check_eq("ovf_before", 32'(overflow), 32'd0);
      press(1, 3, 4'b1000); hold_scans(D + 1); sync_eval(); release_all(); hold_scans(D + 1);
      check_eq("ovf_set", 32'(overflow), 32'(exp_ovf));
      check_eq("ovf_head", 32'(key_code), 32'(sb[0]));
      clear_ovf = 1'b1;
      @(negedge clk);
      clear_ovf = 1'b0;
      exp_ovf = 1'b0;
      check_eq("ovf_clear", 32'(overflow), 32'(exp_ovf));

      // Push and ack in the same cycle while full
      sync_eval();
      pr[2][1] = 1'b1;
      repeat (D * P) @(negedge clk);
      check_eq("pushack_eval", 32'(cols), 32'hF);
      check_eq("pushack_head", 32'(key_code), 32'(sb[0]));
      key_ack = 1'b1;
      void'(sb.pop_front());
      model_push(4'b0101);
      @(negedge clk);
      key_ack = 1'b0;
      check_eq("pushack_ovf", 32'(overflow), 32'(exp_ovf));
      check_eq("pushack_down", 32'(key_down), 32'd1);
      for (int i = 0; i < 4; i++) do_ack("drain");
      sync_eval();
      release_all();
      hold_scans(D + 1);

      // Disable during column 2 settle
      press(3, 3, 4'b0000);
      hold_scans(D + 1);
      check_eq("en_pre_down", 32'(key_down), 32'd1);
      wait_cols(4'b1101, "col2_timeout");
      enable = 1'b0;
      @(negedge clk);
      check_eq("dis_cols", 32'(cols), 32'hF);
      check_eq("dis_down", 32'(key_down), 32'd0);
      check_eq("dis_vld", 32'(key_valid), 32'd1);
      check_eq("dis_code", 32'(key_code), 32'(sb[0]));
      release_all();
      enable = 1'b1;
      @(negedge clk);
      check_eq("reen_col0", 32'(cols), 32'h7);
      hold_scans(D + 1);
      check_eq("reen_code", 32'(key_code), 32'(sb[0]));

      // Reset asserted mid-scan with a non-empty queue and a held key
      press(1, 1, 4'b1010);
      hold_scans(D + 1);
      check_eq("prerst_down", 32'(key_down), 32'd1);
      wait_cols(4'b1011, "col1_timeout");
      #3 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_cols", 32'(cols), 32'hF);
      check_eq("mid_rst_vld", 32'(key_valid), 32'd0);
      check_eq("mid_rst_code", 32'(key_code), 32'd0);
      check_eq("mid_rst_down", 32'(key_down), 32'd0);
      check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
      sb.delete();
      release_all();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
